mic_tick_sched: RTL



---
 rtl/mic_tick_sched.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mic_tick_sched.sv
// mic_tick_sched: shared microsecond/millisecond timebase (clock enables, not
// derived clocks) feeding CH periodic timer channels. Channel expiries are
// reported one at a time through a round-robin arbitrated valid/ready port.
module mic_tick_sched #(
    parameter int  CH       = 4,
    parameter int  CNT_W    = 16,
    parameter int  DIV_W    = 8,
    parameter int  DEF_DIV  = 12,
    parameter int  MS_RATIO = 1000,
    localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             s_clk,
    input  logic             n_rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             us_tick,
    output logic             ms_tick,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CH_W-1:0]  evt_ch,
    output logic             evt_ovr
);
    localparam int MS_W = (MS_RATIO > 1) ? $clog2(MS_RATIO) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             div_pend_q, div_pend_d;
    logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
    logic             tick, ms_hit, cfg_fire;

    logic [CNT_W-1:0] period_q [CH];
    logic [CNT_W-1:0] period_d [CH];
    logic [CNT_W-1:0] cnt_q [CH];
    logic [CNT_W-1:0] cnt_d [CH];
    logic [CH-1:0]    pend_q, pend_d;
    logic [CH-1:0]    ovr_q, ovr_d;
    logic [CH_W-1:0]  rr_last_q, rr_last_d;
    logic             evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
    logic             evt_ovr_q, evt_ovr_d;

    logic             sel_found;
    logic [CH_W-1:0]  sel_idx;
    logic [CH_W:0]    cand;

    assign us_tick   = tick;
    assign ms_tick   = ms_hit;
    assign cfg_ready = !div_pend_q;
    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_ovr   = evt_ovr_q;

    // Prescaler, ms counter and deferred divide update (applied only on a tick
    // so the running period is never truncated)
    always_comb begin
        tick       = (pre_cnt_q == div_q - 1'b1);
        ms_hit     = tick && (ms_cnt_q == MS_W'(MS_RATIO - 1));
        cfg_fire   = cfg_valid && !div_pend_q;
        pre_cnt_d  = tick ? '0 : pre_cnt_q + 1'b1;
        ms_cnt_d   = ms_cnt_q;
        div_d      = div_q;
        shadow_d   = shadow_q;
        div_pend_d = div_pend_q;
        if (tick) begin
            ms_cnt_d = ms_hit ? '0 : ms_cnt_q + 1'b1;
        end
        if (tick && div_pend_q) begin
            div_d      = shadow_q;
            div_pend_d = 1'b0;
        end
        if (cfg_fire && cfg_addr == 3'd0) begin
            // A divide of zero has no meaning; treat it as divide-by-one.
            shadow_d   = (cfg_data[DIV_W-1:0] == '0) ? DIV_W'(1) : cfg_data[DIV_W-1:0];
            div_pend_d = 1'b1;
        end
    end

    // Round-robin search for the first pending channel after rr_last
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < CH; i++) begin
            cand = {1'b0, rr_last_q} + (CH_W+1)'(i + 1);
            if (cand >= (CH_W+1)'(CH)) begin
                cand = cand - (CH_W+1)'(CH);
            end
            if (!sel_found && pend_q[cand[CH_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[CH_W-1:0];
            end
        end
    end

    // Event issue, then channel countdown/expiry; a config write to a channel
    // overrides both for that channel
    always_comb begin
        pend_d      = pend_q;
        ovr_d       = ovr_q;
        rr_last_d   = rr_last_q;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_ovr_d   = evt_ovr_q;
        for (int k = 0; k < CH; k++) begin
            period_d[k] = period_q[k];
            cnt_d[k]    = cnt_q[k];
        end
        if (!evt_valid_q || evt_ready) begin
            evt_valid_d = sel_found;
            if (sel_found) begin
                evt_ch_d         = sel_idx;
                evt_ovr_d        = ovr_q[sel_idx];
                pend_d[sel_idx]  = 1'b0;
                ovr_d[sel_idx]   = 1'b0;
                rr_last_d        = sel_idx;
            end
        end
        for (int k = 0; k < CH; k++) begin
            if (cfg_fire && cfg_addr == 3'(k + 1)) begin
                period_d[k] = cfg_data;
                cnt_d[k]    = cfg_data;
                pend_d[k]   = 1'b0;
                ovr_d[k]    = 1'b0;
            end else if (tick && period_q[k] != '0) begin
                if (cnt_q[k] == CNT_W'(1)) begin
                    cnt_d[k] = period_q[k];
                    // pend_d already reflects a selection this cycle, so an
                    // expiry racing the hand-off re-arms pend instead of
                    // being counted as an overrun.
                    if (pend_d[k]) begin
                        ovr_d[k] = 1'b1;
                    end else begin
                        pend_d[k] = 1'b1;
                    end
                end else begin
                    cnt_d[k] = cnt_q[k] - 1'b1;
                end
            end
        end
    end

    // Timebase registers
    always_ff @(posedge s_clk or negedge n_rst) begin
        if (!n_rst) begin
            div_q      <= DIV_W'(DEF_DIV);
            shadow_q   <= DIV_W'(DEF_DIV);
            pre_cnt_q  <= '0;
            div_pend_q <= 1'b0;
            ms_cnt_q   <= '0;
        end else begin
            div_q      <= div_d;
            shadow_q   <= shadow_d;
            pre_cnt_q  <= pre_cnt_d;
            div_pend_q <= div_pend_d;
            ms_cnt_q   <= ms_cnt_d;
        end
    end

    // Channel state and event output registers
    always_ff @(posedge s_clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < CH; k++) begin
                period_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            pend_q      <= '0;
            ovr_q       <= '0;
            rr_last_q   <= CH_W'(CH - 1);
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_ovr_q   <= 1'b0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                period_q[k] <= period_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            rr_last_q   <= rr_last_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_ovr_q   <= evt_ovr_d;
        end
    end

endmodule
